seq_scan_ctrl: RTL

Controller that schedules a shared serial pattern matcher across parallel input words. It accepts one WORD_W-bit word per handshake and shifts it MSB-first through a programmable PAT_W-bit matcher, one bit per cycle. It counts matches, with overlap allowed or suppressed, and returns the count on an output handshake. It sits between a parallel producer and the FSM sequence-detector datapath, letting many words share one bit-serial detector.

---
 rtl/seq_scan_pkg.sv | 23 ++
 rtl/seq_shift_matcher.sv | 45 ++++
 rtl/seq_scan_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and helpers for the bit-serial pattern scan controller.
// The optional last-match position output is enabled by SEQ_SCAN_POS_EN.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int SEQ_WORD_W = 8;
  localparam int SEQ_POS_W  = $clog2(SEQ_WORD_W + 1);

  // Width needed to hold a 1-based bit index, with 0 meaning "no match".
  function automatic int pos_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

  function automatic logic [31:0] sat_max(input int cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_shift_matcher.sv
// Bit-serial window matcher: keeps the last PAT_W bits plus a fill count so
// that cleared history can never produce a hit, even for an all-zero pattern.
module seq_shift_matcher
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  win;
  logic [FILL_W-1:0] fill;
  logic              full;

  assign win  = (hist << 1) | PAT_W'(bit_in);
  // fill counts bits already in history; the current bit completes the window
  assign full = (fill >= FILL_W'(PAT_W - 1));
  assign hit  = bit_valid & full & (win == pattern);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      if (hit && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= win;
        if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts parallel words and scans them MSB-first through a shared matcher,
// returning a saturating match count. Define SEQ_SCAN_POS_EN for m_last_pos.
//
// state  | meaning
// IDLE   | s_ready high, waiting for a word; accept loads shifter and config
// SHIFT  | one bit per cycle into the matcher, WORD_W cycles
// REPORT | m_valid high, result held until m_ready
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter  int WORD_W = SEQ_WORD_W,
  parameter  int PAT_W  = 4,
  parameter  int CNT_W  = 8,
  localparam int POS_W  = pos_width(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_hit,
  output logic              busy
`ifdef SEQ_SCAN_POS_EN
  ,
  output logic [POS_W-1:0]  m_last_pos
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WORD_W - 1);

  state_t            state, state_n;
  logic [WORD_W-1:0] sreg;
  logic [POS_W-1:0]  bitcnt;
  logic [CNT_W-1:0]  count;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic              accept;
  logic              hit;

  assign accept = (state == IDLE) && s_valid;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) state_n = SHIFT;
      end
      SHIFT:   if (bitcnt == LAST_BIT) state_n = REPORT;
      REPORT: begin
        m_valid = 1'b1;
        if (m_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg   <= '0;
      bitcnt <= '0;
      count  <= '0;
      pat_q  <= '0;
      ovl_q  <= 1'b0;
    end else if (accept) begin
      sreg   <= s_data;
      bitcnt <= '0;
      count  <= '0;
      pat_q  <= cfg_pattern;
      ovl_q  <= cfg_overlap;
    end else if (state == SHIFT) begin
      sreg   <= sreg << 1;
      bitcnt <= bitcnt + 1'b1;
      if (hit && count != CNT_MAX) count <= count + 1'b1;
    end
  end

`ifdef SEQ_SCAN_POS_EN
  logic [POS_W-1:0] last_pos;

  always_ff @(posedge clk) begin
    if (!reset)                    last_pos <= '0;
    else if (accept)               last_pos <= '0;
    else if (state == SHIFT && hit) last_pos <= bitcnt + 1'b1;
  end

  assign m_last_pos = last_pos;
`endif

  seq_shift_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_valid (state == SHIFT),
    .bit_in    (sreg[WORD_W-1]),
    .pattern   (pat_q),
    .overlap   (ovl_q),
    .hit       (hit)
  );

  assign m_count = count;
  assign m_hit   = (count != '0);

endmodule
